// File: rtl/hamming_rx_decoder_if.sv
// ---------------------------------------------------------------------------
// hamming_rx_decoder_if
// Byte stream in, decoded package out, for hamming_rx_decoder.
//
// Signals:
//   rx_data_i        [7:0]  received byte from the RS-232 receiver
//   rx_valid_i              one-cycle strobe, rx_data_i valid
//   data_o           [7:0]  decoded data byte (held until next valid_o)
//   valid_o                 one-cycle strobe, data_o and flags valid
//   corrected_o             single error corrected, qualified by valid_o
//   uncorrectable_o         double/illegal error, qualified by valid_o
//   timeout_o               one-cycle strobe, partial package discarded
//
// Handshake: both directions are valid-only strobes with no ready/backpressure.
// The decoder accepts a byte in every cycle rx_valid_i is high, and the
// consumer must take a result in the single cycle valid_o is high.
//
// Modports: slave = decoder side, master = byte source / result consumer.
// ---------------------------------------------------------------------------
interface hamming_rx_decoder_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       corrected_o;
    logic       uncorrectable_o;
    logic       timeout_o;

    modport slave (
        input  rx_data_i, rx_valid_i,
        output data_o, valid_o, corrected_o, uncorrectable_o, timeout_o
    );

    modport master (
        output rx_data_i, rx_valid_i,
        input  data_o, valid_o, corrected_o, uncorrectable_o, timeout_o
    );
endinterface

// File: rtl/hamming_rx_decoder.sv
// ---------------------------------------------------------------------------
// hamming_rx_decoder
// Assembles two received bytes (high first) into a 16-bit extended Hamming
// package, corrects single errors, flags double errors, and keeps saturating
// counts of corrected and uncorrectable packages. A high byte left waiting
// for TIMEOUT_CYCLES idle cycles is discarded with a timeout_o pulse.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   cnt_clr_i      synchronous clear of both error counters (wins over +1)
//   rx             hamming_rx_decoder_if.slave (byte in, decoded result out)
//   corr_cnt_o     saturating count of corrected packages
//   uncorr_cnt_o   saturating count of uncorrectable packages
//   state_dbg_o    assembly FSM state (0 = IDLE, 1 = WAIT_LOW)
//
// Pipeline: low byte in cycle N -> package register end of N -> decode
// register end of N+1 -> valid_o in cycle N+2.
// ---------------------------------------------------------------------------
module hamming_rx_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cnt_clr_i,
    hamming_rx_decoder_if.slave        rx,
    output logic [15:0]                corr_cnt_o,
    output logic [15:0]                uncorr_cnt_o,
    output logic                       state_dbg_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    // Timeout fires in the idle cycle where the count would reach
    // TIMEOUT_CYCLES; a byte arriving in that same cycle still wins.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
    logic [15:0] pkg_q, pkg_d;
    logic        pkg_vld_q, pkg_vld_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        corr_q, corr_d;
    logic        uncorr_q, uncorr_d;
    logic [15:0] corr_cnt_q, corr_cnt_d;
    logic [15:0] uncorr_cnt_q, uncorr_cnt_d;

    logic [3:0]  syn;
    logic        par;
    logic        dec_corr;
    logic        dec_uncorr;
    logic [15:0] fixed;

    // Byte assembly and timeout
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
        pkg_d     = pkg_q;
        pkg_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx.rx_valid_i) begin
                    hi_d    = rx.rx_data_i;
                    tmo_d   = '0;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (rx.rx_valid_i) begin
                    pkg_d     = {hi_q, rx.rx_data_i};
                    pkg_vld_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Syndrome: each mask selects the positions whose index has bit k set
    // (bit 0, the overall parity, is never part of a syndrome bit).
    always_comb begin
        syn[0] = ^(pkg_q & 16'hAAAA);
        syn[1] = ^(pkg_q & 16'hCCCC);
        syn[2] = ^(pkg_q & 16'hF0F0);
        syn[3] = ^(pkg_q & 16'hFF00);
        par    = ^pkg_q;
    end

    // Correction and data extraction
    always_comb begin
        fixed      = pkg_q;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        if (par) begin
            // Odd overall parity: single error, at position syn (0 = bit 0).
            dec_corr = 1'b1;
            if (syn != 4'd0) begin
                fixed[syn] = ~pkg_q[syn];
            end
        end else if (syn != 4'd0) begin
            dec_uncorr = 1'b1;
        end
    end

    // Decode register and counters; results hold until the next package.
    always_comb begin
        data_d       = data_q;
        corr_d       = corr_q;
        uncorr_d     = uncorr_q;
        valid_d      = pkg_vld_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (pkg_vld_q) begin
            data_d   = {fixed[12:9], fixed[7:5], fixed[3]};
            corr_d   = dec_corr;
            uncorr_d = dec_uncorr;
            if (dec_corr && corr_cnt_q != 16'hFFFF) begin
                corr_cnt_d = corr_cnt_q + 16'd1;
            end
            if (dec_uncorr && uncorr_cnt_q != 16'hFFFF) begin
                uncorr_cnt_d = uncorr_cnt_q + 16'd1;
            end
        end
        if (cnt_clr_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            tmo_q        <= '0;
            timeout_q    <= 1'b0;
            pkg_q        <= '0;
            pkg_vld_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            tmo_q        <= tmo_d;
            timeout_q    <= timeout_d;
            pkg_q        <= pkg_d;
            pkg_vld_q    <= pkg_vld_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign rx.data_o          = data_q;
    assign rx.valid_o         = valid_q;
    assign rx.corrected_o     = corr_q;
    assign rx.uncorrectable_o = uncorr_q;
    assign rx.timeout_o       = timeout_q;
    assign corr_cnt_o         = corr_cnt_q;
    assign uncorr_cnt_o       = uncorr_cnt_q;
    assign state_dbg_o        = state_q;

endmodule
